// File: rtl/lab06_sched_pkg.sv
// Shared types and widths for the lab06 job scheduler.
package lab06_sched_pkg;
    localparam int NIB_W  = 4;
    localparam int MODE_W = 2;
    localparam int RES_W  = 6;

    typedef enum logic [1:0] {IDLE, SEND, WAIT, RESP} state_t;
endpackage

// File: rtl/lab06_rr_arbiter.sv
// Combinational round-robin picker: first asserted request at or above ptr, with wrap.
module lab06_rr_arbiter #(
    parameter int NUM_REQ = 2,
    localparam int IDX_W = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   idx,
    output logic               any
);
    logic [IDX_W-1:0] j;

    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        j     = '0;
        for (int off = 0; off < NUM_REQ; off++) begin
            j = IDX_W'((int'(ptr) + off) % NUM_REQ);
            if (!any && req[j]) begin
                any      = 1'b1;
                grant[j] = 1'b1;
                idx      = j;
            end
        end
    end
endmodule

// File: rtl/lab06_job_sched.sv
// Shares one lab06 engine between NUM_REQ requesters: round-robin grant, burst
// streaming, result/timeout wait, and a tagged valid/ready response.
module lab06_job_sched
    import lab06_sched_pkg::*;
#(
    parameter int NUM_REQ   = 2,
    parameter int BURST_LEN = 4,
    parameter int TIMEOUT   = 64,
    localparam int ID_W   = $clog2(NUM_REQ),
    localparam int K_W    = $clog2(BURST_LEN + 1),
    localparam int T_W    = $clog2(TIMEOUT + 1),
    localparam int DATA_W = NIB_W * BURST_LEN
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [MODE_W*NUM_REQ-1:0]     req_mode,
    input  logic [DATA_W*NUM_REQ-1:0]     req_data,
    output logic                          eng_in_valid,
    output logic [NIB_W-1:0]              eng_in_number,
    output logic [MODE_W-1:0]             eng_mode,
    input  logic                          eng_out_valid,
    input  logic signed [RES_W-1:0]       eng_out_result,
    output logic                          rsp_valid,
    input  logic                          rsp_ready,
    output logic [ID_W-1:0]               rsp_id,
    output logic signed [RES_W-1:0]       rsp_result,
    output logic                          rsp_error,
    output logic                          busy
);
    state_t                  state, state_nx;
    logic [ID_W-1:0]         rr_ptr, id_q;
    logic [MODE_W-1:0]       mode_q;
    logic [DATA_W-1:0]       data_q;
    logic [K_W-1:0]          k_q;
    logic [T_W-1:0]          timer_q;
    logic signed [RES_W-1:0] res_q;
    logic                    err_q;
    logic [NUM_REQ-1:0]      gnt;
    logic [ID_W-1:0]         gnt_idx;
    logic                    gnt_any;
    logic                    last_op, timed_out;

    lab06_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .req   (req_valid),
        .ptr   (rr_ptr),
        .grant (gnt),
        .idx   (gnt_idx),
        .any   (gnt_any)
    );

    assign last_op   = (k_q == K_W'(BURST_LEN - 1));
    assign timed_out = (timer_q == T_W'(TIMEOUT - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            rr_ptr  <= '0;
            id_q    <= '0;
            mode_q  <= '0;
            data_q  <= '0;
            k_q     <= '0;
            timer_q <= '0;
            res_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state <= state_nx;
            case (state)
                IDLE: if (gnt_any) begin
                    id_q   <= gnt_idx;
                    mode_q <= req_mode[gnt_idx*MODE_W +: MODE_W];
                    data_q <= req_data[gnt_idx*DATA_W +: DATA_W];
                    k_q    <= '0;
                    rr_ptr <= (gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
                end
                // Operands are shifted out nibble 0 first.
                SEND: begin
                    data_q  <= data_q >> NIB_W;
                    k_q     <= k_q + 1'b1;
                    timer_q <= '0;
                end
                WAIT: begin
                    timer_q <= timer_q + 1'b1;
                    if (eng_out_valid) begin
                        res_q <= eng_out_result;
                        err_q <= 1'b0;
                    end else if (timed_out) begin
                        res_q <= '0;
                        err_q <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nx      = state;
        req_ready     = '0;
        eng_in_valid  = 1'b0;
        eng_in_number = '0;
        eng_mode      = '0;
        case (state)
            IDLE: if (gnt_any) begin
                // Reset forces IDLE asynchronously; keep the grant quiet while it is held.
                req_ready = rst ? '0 : gnt;
                state_nx  = SEND;
            end
            SEND: begin
                eng_in_valid  = 1'b1;
                eng_in_number = data_q[NIB_W-1:0];
                if (k_q == '0) eng_mode = mode_q;
                if (last_op) state_nx = WAIT;
            end
            WAIT: if (eng_out_valid || timed_out) state_nx = RESP;
            RESP: if (rsp_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    assign rsp_valid  = (state == RESP);
    assign busy       = (state != IDLE);
    assign rsp_id     = id_q;
    assign rsp_result = res_q;
    assign rsp_error  = err_q;
endmodule

// File: doc/lab06_job_sched.md
Name: lab06_job_sched

Overview:
- Job scheduler that shares one lab06 compute engine between NUM_REQ requesters.
- Engine interface: in_valid, in_number[3:0], mode[1:0], out_valid, out_result signed[5:0].
- Each job is one mode plus BURST_LEN 4-bit operands. The block arbitrates round-robin, streams the burst into the engine, and waits for the single out_valid pulse or a timeout.
- It returns the result, tagged with the requester id, over a valid/ready response port.
- Sits between requester logic and the engine instance in the lab top level.

Parameters:
NUM_REQ, 2, number of requesters (2..4)
BURST_LEN, 4, operands streamed per job
TIMEOUT, 64, max cycles waited for eng_out_valid after last operand (>=2)

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous, active-high reset
req_valid  input  NUM_REQ  per-requester job request; held with data stable until req_ready
req_ready  output  NUM_REQ  one-hot, single-cycle grant/accept pulse
req_mode  input  2*NUM_REQ  mode for requester i at [2i+1:2i]
req_data  input  4*BURST_LEN*NUM_REQ  operands; requester i slice, nibble 0 in LSBs sent first
eng_in_valid  output  1  engine operand strobe
eng_in_number  output  4  engine operand
eng_mode  output  2  engine mode, valid only on first burst cycle
eng_out_valid  input  1  engine result strobe
eng_out_result  input  6  engine result, signed
rsp_valid  output  1  response valid, held until rsp_ready
rsp_ready  input  1  response consumer ready
rsp_id  output  $clog2(NUM_REQ)  requester index of job
rsp_result  output  6  signed result (0 on error)
rsp_error  output  1  1 = timeout, no result
busy  output  1  high in every state except IDLE

Behaviour:
- Reset (async, rst=1): state IDLE, rr pointer 0, all outputs 0, timer 0, operand index 0.
- FSM states: IDLE, SEND, WAIT, RESP.
- IDLE:
  - If any req_valid, grant g = first asserted index searching from the rr pointer upward with wrap.
  - Assert req_ready[g] combinationally in this cycle; capture mode, data and id on the edge.
  - rr pointer <= (g+1) mod NUM_REQ.
  - Next state SEND.
  - No req_valid: stay, no grant.
- SEND (exactly BURST_LEN cycles):
  - eng_in_valid=1 and eng_in_number = nibble k, for k = 0..BURST_LEN-1.
  - eng_mode = captured mode when k=0, else 0.
  - After k=BURST_LEN-1: next state WAIT, timer cleared to 0.
  - Bursts are strictly contiguous, no gaps.
- WAIT:
  - eng_in_valid=0; timer increments each cycle.
  - eng_out_valid=1: register eng_out_result into rsp_result, rsp_error=0, go RESP.
  - Timer reaches TIMEOUT-1 without eng_out_valid: rsp_result=0, rsp_error=1, go RESP.
  - eng_out_valid on the same cycle as timeout: the result wins, rsp_error=0.
- RESP:
  - rsp_valid=1, with rsp_id/rsp_result/rsp_error stable until a cycle where rsp_valid&&rsp_ready.
  - Next state IDLE; rsp_valid drops the following cycle.
  - The next grant occurs at the earliest in the IDLE cycle after RESP.
- eng_out_valid in IDLE, SEND or RESP: ignored, no state change.
- Minimum job latency, grant to rsp_valid: 1 + BURST_LEN + engine latency + 1 cycles.
- Fairness: a continuously requesting requester is granted at least once every NUM_REQ jobs.
- req_valid dropped before grant: no grant. Requests are not queued internally.
- Reset mid-job: the job is aborted silently with no response, and eng_in_valid goes low immediately. Integration ties the engine rst_n to ~rst.
- Widths: operand index $clog2(BURST_LEN+1), timer $clog2(TIMEOUT+1), no overflow possible.

Decomposition:
- Package lab06_sched_pkg: state enum type, NIB_W=4, MODE_W=2, RES_W=6.
- Sub-module lab06_rr_arbiter (NUM_REQ):
  - Inputs: req vector, pointer.
  - Outputs: one-hot grant, index, any.
  - Purely combinational.
- The top module holds the FSM, capture registers, timer and pointer update.

Test Plan:
- Single job: req0, mode=2, data=16'h4321, engine model latency 3 returning 6'sd10 → req_ready[0] pulse, eng_in_number 1,2,3,4 on consecutive cycles, eng_mode=2 only on the first, rsp_valid with id=0, result=10, error=0 after 1+4+3+1 cycles.
- Both requesters held high for 4 jobs → grants in order 0,1,0,1; rsp_id in the same order.
- Engine model never responds → rsp_valid with error=1 and result=0 exactly TIMEOUT cycles after the last operand; next job proceeds normally.
- rsp_ready held low 5 cycles with result -7 → rsp_valid/result/id stable for 5 cycles; no new req_ready until after the handshake.
- rst asserted during the 2nd operand of SEND → all outputs 0 the same cycle; after release, req1 alone is granted first (pointer back to 0, req0 idle).
- eng_out_valid arrives on the timeout cycle with -32 → rsp_error=0, rsp_result=-32.
